// File: rtl/asc_line_master.sv
// asc_line_master: Avalon-MM master that turns line commands into the ASC register write/poll sequence.
// Optional feature: `define ASC_MASTER_CHAIN_EN skips the start-point write when a line continues the previous one.
module asc_line_master #(
  parameter int MODE     = 1,
  parameter int POLL_GAP = 4
) (
  input  logic        clk,
  input  logic        reset,
  // Command stream: a command transfers on a rising edge where cmd_valid && cmd_ready.
  // cmd_ready depends only on state, never on cmd_valid; the source must hold fields stable while valid.
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [8:0]  cmd_x0,
  input  logic [8:0]  cmd_x1,
  input  logic [7:0]  cmd_y0,
  input  logic [7:0]  cmd_y1,
  input  logic [2:0]  cmd_colour,
  output logic [2:0]  avm_address,
  output logic        avm_read,
  output logic        avm_write,
  output logic [31:0] avm_writedata,
  input  logic [31:0] avm_readdata,
  input  logic        avm_waitrequest,
  output logic        busy,
  output logic        done,
  output logic [3:0]  dbg_state
);

  typedef enum logic [3:0] {
    S_INIT_MODE = 4'd0,
    S_IDLE      = 4'd1,
    S_WR_START  = 4'd2,
    S_WR_END    = 4'd3,
    S_WR_COLOUR = 4'd4,
    S_WR_GO     = 4'd5,
    S_POLL_WAIT = 4'd6,
    S_POLL_RD   = 4'd7,
    S_DONE      = 4'd8
  } state_t;

  localparam logic [2:0] A_MODE   = 3'd0;
  localparam logic [2:0] A_STATUS = 3'd1;
  localparam logic [2:0] A_GO     = 3'd2;
  localparam logic [2:0] A_START  = 3'd3;
  localparam logic [2:0] A_END    = 3'd4;
  localparam logic [2:0] A_COLOUR = 3'd5;

  localparam bit         MODE_POLL = (MODE % 2) != 0;
  localparam bit         GAP_ZERO  = (POLL_GAP == 0);
  localparam logic [3:0] GAP_LAST  = (POLL_GAP > 0) ? 4'(POLL_GAP - 1) : 4'd0;

  function automatic logic [31:0] point_word(input logic [8:0] x, input logic [7:0] y);
    return {15'd0, y, x};
  endfunction

  state_t      state_q, state_d;
  logic [2:0]  addr_q, addr_d;
  logic        read_q, read_d;
  logic        write_q, write_d;
  logic [31:0] wdata_q, wdata_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [8:0]  x1_q, x1_d;
  logic [7:0]  y1_q, y1_d;
  logic [2:0]  colour_q, colour_d;
  logic        wr_acc, rd_acc, chain_hit;

`ifdef ASC_MASTER_CHAIN_EN
  logic        end_vld_q, end_vld_d;
  logic [8:0]  end_x_q, end_x_d;
  logic [7:0]  end_y_q, end_y_d;
  assign chain_hit = end_vld_q && (cmd_x0 == end_x_q) && (cmd_y0 == end_y_q);
`else
  assign chain_hit = 1'b0;
`endif

  assign wr_acc = write_q && !avm_waitrequest;
  assign rd_acc = read_q && !avm_waitrequest;

  // Only status bit 0 carries meaning; upper readdata bits are deliberately ignored.
  logic unused_readdata;
  assign unused_readdata = ^avm_readdata[31:1];

  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    read_d   = read_q;
    write_d  = write_q;
    wdata_d  = wdata_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    cnt_d    = cnt_q;
    x1_d     = x1_q;
    y1_d     = y1_q;
    colour_d = colour_q;
`ifdef ASC_MASTER_CHAIN_EN
    end_vld_d = end_vld_q;
    end_x_d   = end_x_q;
    end_y_d   = end_y_q;
`endif
    case (state_q)
      S_INIT_MODE: begin
        if (!write_q) begin
          write_d = 1'b1;
          addr_d  = A_MODE;
          wdata_d = {31'd0, MODE_POLL};
        end else if (wr_acc) begin
          write_d = 1'b0;
          state_d = S_IDLE;
        end
      end
      S_IDLE: begin
        if (cmd_valid) begin
          x1_d     = cmd_x1;
          y1_d     = cmd_y1;
          colour_d = cmd_colour;
          busy_d   = 1'b1;
          write_d  = 1'b1;
          if (chain_hit) begin
            state_d = S_WR_END;
            addr_d  = A_END;
            wdata_d = point_word(cmd_x1, cmd_y1);
          end else begin
            state_d = S_WR_START;
            addr_d  = A_START;
            wdata_d = point_word(cmd_x0, cmd_y0);
          end
        end
      end
      S_WR_START: begin
        if (wr_acc) begin
          state_d = S_WR_END;
          addr_d  = A_END;
          wdata_d = point_word(x1_q, y1_q);
        end
      end
      S_WR_END: begin
        if (wr_acc) begin
          state_d = S_WR_COLOUR;
          addr_d  = A_COLOUR;
          wdata_d = {29'd0, colour_q};
`ifdef ASC_MASTER_CHAIN_EN
          end_vld_d = 1'b1;
          end_x_d   = x1_q;
          end_y_d   = y1_q;
`endif
        end
      end
      S_WR_COLOUR: begin
        if (wr_acc) begin
          state_d = S_WR_GO;
          addr_d  = A_GO;
          wdata_d = 32'd0;
        end
      end
      S_WR_GO: begin
        if (wr_acc) begin
          write_d = 1'b0;
          // In stall mode the slave held the go write for the whole draw.
          if (!MODE_POLL) begin
            state_d = S_DONE;
            done_d  = 1'b1;
            busy_d  = 1'b0;
          end else if (GAP_ZERO) begin
            state_d = S_POLL_RD;
            read_d  = 1'b1;
            addr_d  = A_STATUS;
          end else begin
            state_d = S_POLL_WAIT;
            cnt_d   = 4'd0;
          end
        end
      end
      S_POLL_WAIT: begin
        if (cnt_q == GAP_LAST) begin
          state_d = S_POLL_RD;
          read_d  = 1'b1;
          addr_d  = A_STATUS;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      S_POLL_RD: begin
        if (rd_acc) begin
          if (!avm_readdata[0]) begin
            read_d  = 1'b0;
            state_d = S_DONE;
            done_d  = 1'b1;
            busy_d  = 1'b0;
          end else if (!GAP_ZERO) begin
            read_d  = 1'b0;
            state_d = S_POLL_WAIT;
            cnt_d   = 4'd0;
          end
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_INIT_MODE;
        read_d  = 1'b0;
        write_d = 1'b0;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= S_INIT_MODE;
      addr_q   <= 3'd0;
      read_q   <= 1'b0;
      write_q  <= 1'b0;
      wdata_q  <= 32'd0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      cnt_q    <= 4'd0;
      x1_q     <= 9'd0;
      y1_q     <= 8'd0;
      colour_q <= 3'd0;
`ifdef ASC_MASTER_CHAIN_EN
      end_vld_q <= 1'b0;
      end_x_q   <= 9'd0;
      end_y_q   <= 8'd0;
`endif
    end else begin
      state_q  <= state_d;
      addr_q   <= addr_d;
      read_q   <= read_d;
      write_q  <= write_d;
      wdata_q  <= wdata_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      cnt_q    <= cnt_d;
      x1_q     <= x1_d;
      y1_q     <= y1_d;
      colour_q <= colour_d;
`ifdef ASC_MASTER_CHAIN_EN
      end_vld_q <= end_vld_d;
      end_x_q   <= end_x_d;
      end_y_q   <= end_y_d;
`endif
    end
  end

  assign cmd_ready     = (state_q == S_IDLE);
  assign avm_address   = addr_q;
  assign avm_read      = read_q;
  assign avm_write     = write_q;
  assign avm_writedata = wdata_q;
  assign busy          = busy_q;
  assign done          = done_q;
  assign dbg_state     = state_q;

endmodule

// File: tb/tb_asc_line_master.sv
// Bench for asc_line_master: poll-mode and stall-mode instances, a behavioural slave,
// and a transfer-level reference model of the expected register sequence.
`timescale 1ns/1ps
module tb_asc_line_master;
  localparam int GAP = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        cmd_valid;
  logic [8:0]  cmd_x0, cmd_x1;
  logic [7:0]  cmd_y0, cmd_y1;
  logic [2:0]  cmd_colour;
  logic [31:0] avm_readdata = 32'd0;
  logic        avm_waitrequest = 1'b0;

  logic        r1_ready, r1_read, r1_write, r1_busy, r1_done;
  logic [2:0]  r1_addr;
  logic [31:0] r1_wdata;
  logic [3:0]  r1_dbg;
  logic        r0_ready, r0_read, r0_write, r0_busy, r0_done;
  logic [2:0]  r0_addr;
  logic [31:0] r0_wdata;
  logic [3:0]  r0_dbg;

  logic        sel0 = 1'b0;
  logic        m_ready, m_read, m_write, m_busy, m_done;
  logic [2:0]  m_addr;
  logic [31:0] m_wdata;
  assign m_ready = sel0 ? r0_ready : r1_ready;
  assign m_read  = sel0 ? r0_read  : r1_read;
  assign m_write = sel0 ? r0_write : r1_write;
  assign m_busy  = sel0 ? r0_busy  : r1_busy;
  assign m_done  = sel0 ? r0_done  : r1_done;
  assign m_addr  = sel0 ? r0_addr  : r1_addr;
  assign m_wdata = sel0 ? r0_wdata : r1_wdata;

  always #5 clk = ~clk;

  asc_line_master #(.MODE(1), .POLL_GAP(GAP)) u_dut1 (
    .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(r1_ready),
    .cmd_x0(cmd_x0), .cmd_x1(cmd_x1), .cmd_y0(cmd_y0), .cmd_y1(cmd_y1), .cmd_colour(cmd_colour),
    .avm_address(r1_addr), .avm_read(r1_read), .avm_write(r1_write), .avm_writedata(r1_wdata),
    .avm_readdata(avm_readdata), .avm_waitrequest(avm_waitrequest),
    .busy(r1_busy), .done(r1_done), .dbg_state(r1_dbg)
  );

  asc_line_master #(.MODE(0), .POLL_GAP(GAP)) u_dut0 (
    .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(r0_ready),
    .cmd_x0(cmd_x0), .cmd_x1(cmd_x1), .cmd_y0(cmd_y0), .cmd_y1(cmd_y1), .cmd_colour(cmd_colour),
    .avm_address(r0_addr), .avm_read(r0_read), .avm_write(r0_write), .avm_writedata(r0_wdata),
    .avm_readdata(avm_readdata), .avm_waitrequest(avm_waitrequest),
    .busy(r0_busy), .done(r0_done), .dbg_state(r0_dbg)
  );

  // Slave model: status stays 1 until busy_until reads have been accepted.
  bit          rand_wait = 1'b0;
  logic [2:0]  stall_addr = 3'd0;
  int          stall_until = 0;
  int          stall_cnt = 0;
  int          busy_until = 0;
  int          rd_acc_total = 0;
  logic [31:0] junk;
  always @(posedge clk) begin
    #1;
    junk = $urandom();
    if (m_write && m_addr == stall_addr && stall_cnt < stall_until) begin
      avm_waitrequest = 1'b1;
      stall_cnt++;
    end else if (rand_wait) begin
      avm_waitrequest = ($urandom_range(0, 99) < 35);
    end else begin
      avm_waitrequest = 1'b0;
    end
    if (m_read)
      avm_readdata = {junk[31:1], avm_waitrequest ? 1'b1 : (rd_acc_total < busy_until)};
    else
      avm_readdata = junk;
  end

  // Transfer monitor: entry = {is_read, address, writedata}
  logic [35:0] obs_q[$];
  logic [35:0] exp_q[$];
  int          obs_rd = 0;
  int          r0_reads = 0;
  int          overlap = 0;
  always @(negedge clk) begin
    if (reset) begin
      if (m_write && !avm_waitrequest) obs_q.push_back({1'b0, m_addr, m_wdata});
      if (m_read && !avm_waitrequest) begin
        obs_q.push_back({1'b1, m_addr, 32'd0});
        rd_acc_total++;
      end
    end
    if (r0_read) r0_reads++;
    if ((r0_read && r0_write) || (r1_read && r1_write)) overlap++;
  end

  int total = 0;
  int bad = 0;
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic check_seq(input string tag);
    chk({tag, "_len"}, 64'(obs_q.size() - obs_rd), 64'(exp_q.size()));
    while (exp_q.size() > 0) begin
      if (obs_rd < obs_q.size()) begin
        chk({tag, "_xfer"}, 64'(obs_q[obs_rd]), 64'(exp_q[0]));
        obs_rd++;
      end
      void'(exp_q.pop_front());
    end
    obs_rd = obs_q.size();
  endtask

  // Reference model: which registers a command touches and how long it should take.
  bit have_end = 1'b0;
  int end_x = 0;
  int end_y = 0;
  task automatic model_cmd(input int x0, input int y0, input int x1, input int y1, input int col,
                           input int busy_n, input bit mode1, output int lat);
    int n_wr;
    bit skip;
    n_wr = 3;
    skip = 1'b0;
`ifdef ASC_MASTER_CHAIN_EN
    skip = have_end && x0 == end_x && y0 == end_y;
`endif
    if (!skip) begin
      exp_q.push_back({1'b0, 3'd3, 32'(y0 * 512 + x0)});
      n_wr++;
    end
    exp_q.push_back({1'b0, 3'd4, 32'(y1 * 512 + x1)});
    exp_q.push_back({1'b0, 3'd5, 32'(col)});
    exp_q.push_back({1'b0, 3'd2, 32'd0});
    if (mode1)
      for (int k = 0; k <= busy_n; k++) exp_q.push_back({1'b1, 3'd1, 32'd0});
    lat = n_wr + (mode1 ? (busy_n + 1) * (GAP + 1) : 0) + 1;
    have_end = 1'b1;
    end_x = x1;
    end_y = y1;
  endtask

  // Called at a negedge; returns at the first negedge after the handshake edge.
  task automatic issue(input int x0, input int y0, input int x1, input int y1, input int col);
    int i;
    i = 0;
    while (!m_ready && i < 500) begin
      @(negedge clk);
      i++;
    end
    chk("cmd_ready_idle", 64'(m_ready), 64'd1);
    cmd_valid  = 1'b1;
    cmd_x0     = 9'(x0);
    cmd_y0     = 8'(y0);
    cmd_x1     = 9'(x1);
    cmd_y1     = 8'(y1);
    cmd_colour = 3'(col);
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
    @(negedge clk);
    chk("busy_rise", 64'(m_busy), 64'd1);
  endtask

  task automatic finish_cmd(input string tag, input int lat_exp, input bit check_lat);
    int n;
    n = 1;
    while (!m_done && n < 3000) begin
      @(negedge clk);
      n++;
    end
    cmd_valid = 1'b0;
    chk({tag, "_done"}, 64'(m_done), 64'd1);
    if (check_lat) chk({tag, "_latency"}, 64'(n), 64'(lat_exp));
    chk({tag, "_busy_fall"}, 64'(m_busy), 64'd0);
    @(negedge clk);
    chk({tag, "_done_pulse"}, 64'(m_done), 64'd0);
    chk({tag, "_ready_again"}, 64'(m_ready), 64'd1);
    check_seq(tag);
  endtask

  initial begin
    int lat, x0, y0, x1, y1, col, bn, i, go_cyc, base;
    reset = 1'b0;
    cmd_valid = 1'b0;
    cmd_x0 = '0; cmd_y0 = '0; cmd_x1 = '0; cmd_y1 = '0; cmd_colour = '0;

    // Reset values and the mode write after release
    repeat (3) @(negedge clk);
    chk("rst_ready", 64'(m_ready), 64'd0);
    chk("rst_write", 64'(m_write), 64'd0);
    chk("rst_read", 64'(m_read), 64'd0);
    chk("rst_addr", 64'(m_addr), 64'd0);
    chk("rst_wdata", 64'(m_wdata), 64'd0);
    chk("rst_busy_done", 64'({m_busy, m_done}), 64'd0);
    reset = 1'b1;
    i = 0;
    @(negedge clk);
    while (!(m_write && !avm_waitrequest) && i < 50) begin
      @(negedge clk);
      i++;
    end
    chk("init_ready_low", 64'(m_ready), 64'd0);
    @(negedge clk);
    chk("init_ready_rise", 64'(m_ready), 64'd1);
    exp_q.push_back({1'b0, 3'd0, 32'd1});
    check_seq("init");

    // Reference line with two busy polls
    busy_until = rd_acc_total + 2;
    model_cmd(10, 20, 300, 100, 5, 2, 1'b1, lat);
    issue(10, 20, 300, 100, 5);
    finish_cmd("cmd_a", lat, 1'b1);

    // Continues from (300,100); minimum latency, first poll idle
    busy_until = rd_acc_total;
    model_cmd(300, 100, 50, 60, 2, 0, 1'b1, lat);
    issue(300, 100, 50, 60, 2);
    finish_cmd("cmd_b", lat, 1'b1);

    // End-point write stalled 3 cycles; command source keeps valid high while busy
    busy_until = rd_acc_total + 1;
    stall_addr = 3'd4;
    stall_until = stall_cnt + 3;
    model_cmd(7, 8, 20, 30, 1, 1, 1'b1, lat);
    issue(7, 8, 20, 30, 1);
    cmd_valid = 1'b1;
    cmd_x0 = 9'd99; cmd_y0 = 8'd99; cmd_x1 = 9'd11; cmd_y1 = 8'd12; cmd_colour = 3'd6;
    i = 0;
    while (!(m_write && m_addr == 3'd4) && i < 50) begin
      @(negedge clk);
      i++;
    end
    for (int k = 0; k < 4; k++) begin
      chk("stall_addr", 64'(m_addr), 64'd4);
      chk("stall_wdata", 64'(m_wdata), 64'(30 * 512 + 20));
      chk("stall_write", 64'(m_write), 64'd1);
      @(negedge clk);
    end
    chk("after_stall_addr", 64'({m_write, m_addr}), 64'({1'b1, 3'd5}));
    finish_cmd("cmd_c", lat, 1'b0);

    // Random lines, random waitrequest, random busy poll counts
    rand_wait = 1'b1;
    for (int n = 0; n < 8; n++) begin
      if ($urandom_range(0, 1) == 1 && have_end) begin
        x0 = end_x;
        y0 = end_y;
      end else begin
        x0 = $urandom_range(0, 511);
        y0 = $urandom_range(0, 255);
      end
      x1  = $urandom_range(0, 511);
      y1  = $urandom_range(0, 255);
      col = $urandom_range(0, 7);
      bn  = $urandom_range(0, 3);
      busy_until = rd_acc_total + bn;
      model_cmd(x0, y0, x1, y1, col, bn, 1'b1, lat);
      issue(x0, y0, x1, y1, col);
      finish_cmd("rand", lat, 1'b0);
    end
    rand_wait = 1'b0;

    // Reset while waiting between polls: abandon, re-run mode write, no resume
    busy_until = rd_acc_total + 5;
    base = rd_acc_total;
    issue(1, 2, 3, 4, 3);
    i = 0;
    while (rd_acc_total == base && i < 500) begin
      @(negedge clk);
      i++;
    end
    chk("rst_reached_poll", 64'(rd_acc_total > base), 64'd1);
    @(negedge clk);
    #1;
    reset = 1'b0;
    #1;
    chk("async_rst_strobes", 64'({m_read, m_write}), 64'd0);
    chk("async_rst_bus", 64'({m_addr, m_wdata}), 64'd0);
    chk("async_rst_status", 64'({m_ready, m_busy, m_done}), 64'd0);
    obs_rd = obs_q.size();
    have_end = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    exp_q.push_back({1'b0, 3'd0, 32'd1});
    repeat (40) @(negedge clk);
    check_seq("rst_resume");
    chk("rst_resume_idle", 64'({m_busy, m_ready}), 64'({1'b0, 1'b1}));

    // Stall-mode instance: go write held 50 cycles, no polling
    @(negedge clk);
    reset = 1'b0;
    sel0 = 1'b1;
    repeat (2) @(negedge clk);
    obs_rd = obs_q.size();
    reset = 1'b1;
    have_end = 1'b0;
    exp_q.push_back({1'b0, 3'd0, 32'd0});
    repeat (6) @(negedge clk);
    check_seq("m0_init");
    base = r0_reads;
    stall_addr = 3'd2;
    stall_until = stall_cnt + 50;
    model_cmd(10, 20, 300, 100, 5, 0, 1'b0, lat);
    issue(10, 20, 300, 100, 5);
    go_cyc = 0;
    i = 0;
    while (i < 500) begin
      if (m_write && m_addr == 3'd2) begin
        go_cyc++;
        if (!avm_waitrequest) break;
      end
      @(negedge clk);
      i++;
    end
    chk("m0_go_cycles", 64'(go_cyc), 64'd51);
    chk("m0_done_early", 64'(m_done), 64'd0);
    @(negedge clk);
    chk("m0_done", 64'(m_done), 64'd1);
    chk("m0_busy_fall", 64'(m_busy), 64'd0);
    chk("m0_no_reads", 64'(r0_reads - base), 64'd0);
    check_seq("m0_seq");

    chk("no_rd_wr_overlap", 64'(overlap), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/asc_line_master.md
# asc_line_master

Avalon-MM master that drives the line-drawing accelerator (ASC) register slave. It accepts line commands from a valid/ready stream and issues the register write sequence mode → start point → end point → colour → go. It then polls the status register until drawing completes and returns a one-cycle completion pulse. It sits between the command source (CPU-side FIFO or test sequencer) and the ASC slave port.

## Interface
Parameters:
- MODE, 1, value written to ASC mode register after reset (0 = stall mode, 1 = poll mode).
- POLL_GAP, 4, idle cycles between consecutive status reads (0..15).

Ports:
- clk  input  1  system clock; all state on rising edge.
- reset  input  1  asynchronous, active-low reset (asserted = 0).
- cmd_valid  input  1  command available.
- cmd_ready  output  1  master accepts command this cycle.
- cmd_x0 / cmd_x1  input  9  line start/end x.
- cmd_y0 / cmd_y1  input  8  line start/end y.
- cmd_colour  input  3  line colour.
- avm_address  output  3  ASC register index.
- avm_read  output  1  read strobe.
- avm_write  output  1  write strobe.
- avm_writedata  output  32  write data.
- avm_readdata  input  32  read data, valid when avm_read=1 and avm_waitrequest=0.
- avm_waitrequest  input  1  slave stall.
- busy  output  1  high from command accept until done.
- done  output  1  one-cycle pulse when the line finishes.

## Operation
- Register map: 0 mode, 1 status, 2 go, 3 start point, 4 end point, 5 colour.
- Point word: {15'd0, y[7:0], x[8:0]}. Colour word: {29'd0, colour}. Go word: 32'd0. Mode word: {31'd0, MODE[0]}.
- The master does not clamp coordinates; the slave saturates x at 335 and y at 209.
- States: INIT_MODE → IDLE → WR_START → WR_END → WR_COLOUR → WR_GO → (MODE=1: POLL_WAIT ↔ POLL_RD) → DONE → IDLE.
- INIT_MODE: after reset release, write mode once. Then go to IDLE.
- IDLE: cmd_ready=1. A handshake (cmd_valid & cmd_ready) latches all cmd_* fields into internal registers and moves to WR_START.
- WR_*: hold address/write/writedata stable until the cycle with avm_write=1 and avm_waitrequest=0, then advance.
- After WR_GO completes with MODE=0: the slave stalled the go write for the whole draw, so go directly to DONE.
- After WR_GO completes with MODE=1: enter POLL_WAIT. Count POLL_GAP cycles with outputs idle, then go to POLL_RD.
- POLL_RD: read address 1 until the read is accepted. If avm_readdata[0]=1, return to POLL_WAIT. If 0, go to DONE.
- DONE: done=1 for one cycle, busy falls, return to IDLE.
- Reset mid-operation: the transaction is abandoned, all outputs return to reset values immediately, and INIT_MODE re-runs on release.

## Timing
- Reset values: cmd_ready=0, avm_read=0, avm_write=0, avm_address=0, avm_writedata=0, busy=0, done=0. The FSM is in INIT_MODE.
- All outputs are registered, except that cmd_ready is decoded from state (=1 only in IDLE).
- avm_read and avm_write are never asserted together.
- There are no idle cycles between consecutive write transfers: the next write's strobe is asserted the cycle after the previous one is accepted.
- Minimum latency, accept → done, no waitrequest, MODE=1, first poll returns 0: 4 writes + POLL_GAP + 1 read + 1 = 10 cycles with POLL_GAP=4.
- busy rises the cycle after the handshake and falls with the done pulse. A new command can be accepted the cycle after done.
- cmd_valid while busy is ignored (not latched).
- A readdata value with status=1 arriving at the same time as waitrequest is ignored; only accepted reads are evaluated.

## Configuration
- ASC_MASTER_CHAIN_EN defined: the last written end point is stored. If the new command's (x0,y0) equals the stored end point and a previous line has been drawn since reset, WR_START is skipped (polyline chaining). The stored point is cleared on reset.
- ASC_MASTER_CHAIN_EN not defined: the start point is always written; there is no stored point.

## Test plan
- Reset release, waitrequest=0 → first transfer is a write to address 0 with data 1; cmd_ready rises in the following cycle.
- Command x0=10,y0=20,x1=300,y1=100,colour=5 → writes addr3=0x0000280A, addr4=0x0000C92C, addr5=5, addr2=0. Then status reads (1,1,0) → done pulse after the third read; busy low afterward.
- waitrequest held high for 3 cycles during the addr4 write → address and writedata stay stable for all 4 cycles; addr5 write starts in the cycle after acceptance.
- MODE=0, waitrequest high for 50 cycles on the go write → no reads issued; done pulse one cycle after the go write is accepted.
- Reset asserted during POLL_WAIT → outputs zero asynchronously; after release, the mode write re-issues and the old command is not resumed.
- With ASC_MASTER_CHAIN_EN, a second command whose start point equals the first command's end point (300,100) → no addr3 write, sequence begins at addr4. Without the macro, addr3 is written.
